mem_access_arbiter: RTL and testbench

Two-requester arbiter that shares a single memory access engine (start_wr/start_rd/done_wr/done_rd handshake) between the UART command controller (port 0) and a second client (port 1). It serialises requests with round-robin fairness, latches address/data at grant, issues one start pulse, waits for the matching done, and returns acknowledge plus read data to the winner. It sits between the command controllers and the memory write/read engines.

---
 rtl/mem_access_arbiter_pkg.sv | 31 +++
 rtl/mem_access_arbiter_rr2.sv | 13 +
 rtl/mem_access_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_arbiter_pkg.sv
// Shared encodings for mem_access_arbiter: FSM states, engine operation codes
// and the one-hot state display pattern.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_t;

  localparam logic [2:0] SLEDS_IDLE  = 3'b000;
  localparam logic [2:0] SLEDS_ISSUE = 3'b001;
  localparam logic [2:0] SLEDS_WAIT  = 3'b010;
  localparam logic [2:0] SLEDS_RESP  = 3'b100;

  function automatic logic [2:0] state_leds(input state_t s);
    case (s)
      ISSUE:   return SLEDS_ISSUE;
      WAIT:    return SLEDS_WAIT;
      RESP:    return SLEDS_RESP;
      default: return SLEDS_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_arbiter_rr2.sv
// arb_rr2: combinational two-way round-robin pick. On a tie the port that was
// not served last wins; otherwise the single pending port wins.
module arb_rr2 (
  input  logic [1:0] i_pending,
  input  logic       i_last_served,
  output logic       o_grant,
  output logic       o_valid
);

  assign o_valid = |i_pending;
  assign o_grant = (&i_pending) ? ~i_last_served : i_pending[1];

endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares one memory access engine between two ports with
// round-robin fairness. Defining ARB_TIMEOUT_EN adds a WAIT timeout with error response.
module mem_access_arbiter
  import arb_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_wr,
  input  logic          req0_rd,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req1_wr,
  input  logic          req1_rd,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  output logic          err0,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          err1,
  output logic          start_wr,
  output logic          start_rd,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  input  logic          done_wr,
  input  logic          done_rd,
  input  logic [DW-1:0] rdata,
  output logic          busy,
  output logic [2:0]    sleds
);

  logic [1:0]    w_req_wr;
  logic [1:0]    w_req_rd;
  logic [AW-1:0] w_req_addr  [2];
  logic [DW-1:0] w_req_wdata [2];
  logic          w_grant;
  logic          w_grant_valid;
  logic          w_match;
  logic          w_timeout;
  logic [1:0]    w_ack;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_port;
  logic          r_last_served;
  op_t           r_op;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_start_wr;
  logic          r_start_rd;
  logic          r_err;
  logic [DW-1:0] r_rdata [2];

  assign w_req_wr       = {req1_wr, req0_wr};
  assign w_req_rd       = {req1_rd, req0_rd};
  assign w_req_addr[0]  = req0_addr;
  assign w_req_addr[1]  = req1_addr;
  assign w_req_wdata[0] = req0_wdata;
  assign w_req_wdata[1] = req1_wdata;

  arb_rr2 u_rr2 (
    .i_pending     (w_req_wr | w_req_rd),
    .i_last_served (r_last_served),
    .o_grant       (w_grant),
    .o_valid       (w_grant_valid)
  );

  // Only the done matching the latched op ends WAIT.
  assign w_match = (r_op == OP_WR) ? done_wr : done_rd;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || (r_state != WAIT)) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // The WAIT cycle that would bring the count to TIMEOUT is the last one.
  assign w_timeout = (r_state == WAIT) && (r_wait_cnt == CW'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_grant_valid) w_state_next = ISSUE;
      ISSUE:   w_state_next = WAIT;
      WAIT:    if (w_match || w_timeout) w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_port        <= 1'b0;
      r_last_served <= 1'b1;
      r_op          <= OP_WR;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_start_wr    <= 1'b0;
      r_start_rd    <= 1'b0;
      r_err         <= 1'b0;
      r_rdata[0]    <= '0;
      r_rdata[1]    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_start_wr <= 1'b0;
      r_start_rd <= 1'b0;
      case (r_state)
        IDLE: begin
          // A port asking for both ops gets the write now; its read stays pending.
          if (w_grant_valid) begin
            r_port     <= w_grant;
            r_op       <= w_req_wr[w_grant] ? OP_WR : OP_RD;
            r_addr     <= w_req_addr[w_grant];
            r_wdata    <= w_req_wdata[w_grant];
            r_start_wr <= w_req_wr[w_grant];
            r_start_rd <= ~w_req_wr[w_grant];
          end
        end
        WAIT: begin
          if (w_match) begin
            if (r_op == OP_RD) r_rdata[r_port] <= rdata;
            r_err <= 1'b0;
          end else if (w_timeout) begin
            r_rdata[r_port] <= '0;
            r_err           <= 1'b1;
          end
        end
        RESP:    r_last_served <= r_port;
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign w_ack[gi] = (r_state == RESP) && (r_port == 1'(gi));
  end

  assign ack0     = w_ack[0];
  assign ack1     = w_ack[1];
  assign err0     = w_ack[0] & r_err;
  assign err1     = w_ack[1] & r_err;
  assign rdata0   = r_rdata[0];
  assign rdata1   = r_rdata[1];
  assign start_wr = r_start_wr;
  assign start_rd = r_start_rd;
  assign addr     = r_addr;
  assign wdata    = r_wdata;
  assign busy     = (r_state != IDLE);
  assign sleds    = state_leds(r_state);

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level reference model.
module tb_mem_access_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_wr = 1'b0, req0_rd = 1'b0, req1_wr = 1'b0, req1_rd = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
  logic          done_wr = 1'b0, done_rd = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic          ack0, ack1, err0, err1, start_wr, start_rd, busy;
  logic [DW-1:0] rdata0, rdata1, wdata;
  logic [AW-1:0] addr;
  logic [2:0]    sleds;

  always #5 clk = ~clk;

  mem_access_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_wr(req0_wr), .req0_rd(req0_rd), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_wr(req1_wr), .req1_rd(req1_rd), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .start_wr(start_wr), .start_rd(start_rd), .addr(addr), .wdata(wdata),
    .done_wr(done_wr), .done_rd(done_rd), .rdata(rdata),
    .busy(busy), .sleds(sleds)
  );

  typedef struct {
    int         port;
    logic       wr;
    logic       rd;
    logic [7:0] a;
    logic [7:0] d;
    int         dly;
    logic [7:0] eng;
    logic       exp_wr;
    logic [7:0] exp_own;
    logic [7:0] exp_other;
  } vec_t;

  vec_t vecs[6];

  int n_checks = 0;
  int n_pass   = 0;

  // Results captured by run_txn
  int         t_start_lat, t_ack_lat, t_ack_port;
  logic       t_swr, t_srd, t_err;
  logic [7:0] t_addr, t_wdata, t_rd0, t_rd1;
  logic [2:0] t_sleds;

  // Reference model state for the randomized run
  logic       p_wr[2], p_rd[2];
  logic [7:0] p_addr[2], p_wd[2], m_rdata[2];
  logic       m_last, m_inflight, m_idle_prev, m_port, m_op_wr, exp_start, exp_ack, busy_now;
  logic [7:0] m_addr, m_wd, m_eng;
  int         m_start_cyc, m_done_cyc, n_txn, kind, lat;
  logic       saw;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic set_req(input int p, input logic wr, input logic rd,
                         input logic [7:0] a, input logic [7:0] d);
    if (p == 0) begin
      req0_wr = wr; req0_rd = rd; req0_addr = a; req0_wdata = d;
    end else begin
      req1_wr = wr; req1_rd = rd; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    done_wr = 1'b0; done_rd = 1'b0; rdata = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits for a start, answers with the matching done after dly cycles, waits for the ack.
  task automatic run_txn(input int dly, input logic [7:0] eng);
    t_start_lat = -1; t_ack_lat = -1; t_ack_port = -1;
    t_swr = 1'b0; t_srd = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (start_wr || start_rd) begin
        t_start_lat = i; t_swr = start_wr; t_srd = start_rd;
        t_addr = addr; t_wdata = wdata;
        break;
      end
    end
    if (t_start_lat < 0) return;
    repeat (dly) @(negedge clk);
    if (t_swr) done_wr = 1'b1;
    else done_rd = 1'b1;
    rdata = eng;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      done_wr = 1'b0; done_rd = 1'b0;
      if (ack0 || ack1) begin
        t_ack_lat = i; t_ack_port = ack1 ? 1 : 0;
        t_rd0 = rdata0; t_rd1 = rdata1; t_err = err0 | err1; t_sleds = sleds;
        break;
      end
    end
  endtask

  initial begin
    vecs[0] = '{0, 1'b1, 1'b0, 8'h12, 8'hA5, 2, 8'h00, 1'b1, 8'h00, 8'h00};
    vecs[1] = '{1, 1'b0, 1'b1, 8'h40, 8'h00, 1, 8'h3C, 1'b0, 8'h3C, 8'h00};
    vecs[2] = '{0, 1'b0, 1'b1, 8'h7F, 8'h00, 3, 8'h5A, 1'b0, 8'h5A, 8'h3C};
    vecs[3] = '{1, 1'b1, 1'b0, 8'hFF, 8'h11, 1, 8'h99, 1'b1, 8'h3C, 8'h5A};
    vecs[4] = '{0, 1'b0, 1'b1, 8'h00, 8'h00, 4, 8'hC3, 1'b0, 8'hC3, 8'h3C};
    vecs[5] = '{1, 1'b0, 1'b1, 8'h80, 8'h00, 2, 8'h00, 1'b0, 8'h00, 8'hC3};

    // Reset state
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_sleds", sleds, 0);
    check("rst_start", {start_wr, start_rd}, 0);
    check("rst_ack_err", {ack0, ack1, err0, err1}, 0);
    check("rst_addr_wdata", {addr, wdata}, 0);
    check("rst_rdata", {rdata0, rdata1}, 0);

    // Directed single transactions
    for (int i = 0; i < 6; i++) begin
      set_req(vecs[i].port, vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].d);
      run_txn(vecs[i].dly, vecs[i].eng);
      check("vec_start_lat", t_start_lat, 1);
      check("vec_start_op", {t_swr, t_srd}, {vecs[i].exp_wr, ~vecs[i].exp_wr});
      check("vec_addr", t_addr, vecs[i].a);
      check("vec_wdata", t_wdata, vecs[i].d);
      check("vec_ack_lat", t_ack_lat, 1);
      check("vec_ack_port", t_ack_port, vecs[i].port);
      check("vec_rdata_own", (vecs[i].port == 0) ? t_rd0 : t_rd1, vecs[i].exp_own);
      check("vec_rdata_other", (vecs[i].port == 0) ? t_rd1 : t_rd0, vecs[i].exp_other);
      check("vec_err", t_err, 0);
      check("vec_sleds_resp", t_sleds, 3'b100);
      set_req(vecs[i].port, 1'b0, 1'b0, vecs[i].a, vecs[i].d);
      @(negedge clk);
      check("vec_idle_after", busy, 0);
      $display("vec %0d: port %0d %s addr 0x%02h ack_port %0d rdata0 0x%02h rdata1 0x%02h",
               i, vecs[i].port, vecs[i].exp_wr ? "WR" : "RD", t_addr, t_ack_port, t_rd0, t_rd1);
    end

    // Both ports writing continuously from reset: grants alternate starting with port 0
    do_reset();
    set_req(0, 1'b1, 1'b0, 8'h10, 8'hA0);
    set_req(1, 1'b1, 1'b0, 8'h20, 8'hB0);
    for (int i = 0; i < 4; i++) begin
      run_txn(1, 8'h00);
      check("alt_port", t_ack_port, i % 2);
      check("alt_addr", t_addr, (i % 2) ? 8'h20 : 8'h10);
      check("alt_start_lat", t_start_lat, (i == 0) ? 1 : 2);
      $display("alt %0d: ack_port %0d addr 0x%02h", i, t_ack_port, t_addr);
    end
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);

    // Write and read together: write first, then read as its own transaction
    set_req(0, 1'b1, 1'b1, 8'h33, 8'h44);
    run_txn(1, 8'h77);
    check("wrrd_first_op", {t_swr, t_srd}, 2'b10);
    check("wrrd_first_rdata", t_rd0, 8'h00);
    $display("wrrd 0: op WR addr 0x%02h rdata0 0x%02h", t_addr, t_rd0);
    set_req(0, 1'b0, 1'b1, 8'h33, 8'h44);
    run_txn(2, 8'h77);
    check("wrrd_second_op", {t_swr, t_srd}, 2'b01);
    check("wrrd_second_lat", t_start_lat, 2);
    check("wrrd_second_rdata", t_rd0, 8'h77);
    $display("wrrd 1: op RD addr 0x%02h rdata0 0x%02h", t_addr, t_rd0);
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);

    // Read whose engine never answers
    set_req(0, 1'b0, 1'b1, 8'h55, 8'h00);
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (start_rd) begin saw = 1'b1; break; end
    end
    check("to_start", saw, 1);
`ifdef ARB_TIMEOUT_EN
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        lat = i;
        check("to_ack0", ack0, 1);
        check("to_err0", err0, 1);
        check("to_rdata0", rdata0, 8'h00);
        break;
      end
    end
    check("to_ack_lat", lat, TO + 1);
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    $display("timeout: ack after %0d cycles", lat);
`else
    saw = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (ack0 || ack1) saw = 1'b1;
    end
    check("noto_no_ack", saw, 0);
    check("noto_still_busy", busy, 1);
    $display("timeout: none, no ack within 300 cycles");
`endif
    do_reset();

    // Mismatched done ignored in WAIT, then reset mid-transaction
    set_req(1, 1'b0, 1'b1, 8'h44, 8'h00);
    @(negedge clk);
    check("mid_start_rd", start_rd, 1);
    check("mid_sleds_issue", sleds, 3'b001);
    @(negedge clk);
    check("mid_sleds_wait", sleds, 3'b010);
    done_wr = 1'b1;
    @(negedge clk);
    done_wr = 1'b0;
    check("mid_mismatch_no_ack", ack1, 0);
    check("mid_still_wait", sleds, 3'b010);
    rst = 1'b1;
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sleds", sleds, 0);
    check("mid_rst_addr", addr, 0);
    check("mid_rst_outs", {start_wr, start_rd, ack0, ack1, err0, err1}, 0);
    done_rd = 1'b1;
    rdata = 8'hEE;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      done_rd = 1'b0;
      if (ack0 || ack1) saw = 1'b1;
    end
    check("mid_late_done_ignored", saw, 0);
    check("mid_rdata1", rdata1, 0);
    $display("midrst: late done_rd ack seen %0d", saw);

    // Randomized run against the transaction-level model
    do_reset();
    m_last = 1'b1; m_inflight = 1'b0; m_idle_prev = 1'b1; n_txn = 0;
    m_port = 1'b0; m_op_wr = 1'b0; m_addr = '0; m_wd = '0; m_eng = '0;
    m_start_cyc = -10; m_done_cyc = -10;
    for (int p = 0; p < 2; p++) begin
      p_wr[p] = 1'b0; p_rd[p] = 1'b0; p_addr[p] = '0; p_wd[p] = '0; m_rdata[p] = '0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      exp_start = 1'b0;
      if (m_idle_prev && (p_wr[0] | p_rd[0] | p_wr[1] | p_rd[1])) begin
        if ((p_wr[0] | p_rd[0]) && (p_wr[1] | p_rd[1])) m_port = ~m_last;
        else m_port = p_wr[1] | p_rd[1];
        m_op_wr = p_wr[m_port];
        m_addr = p_addr[m_port];
        m_wd = p_wd[m_port];
        m_inflight = 1'b1;
        exp_start = 1'b1;
        m_start_cyc = cyc;
        m_done_cyc = cyc + int'($urandom_range(1, 4));
        m_eng = 8'($urandom_range(0, 255));
      end
      check("rnd_start_wr", start_wr, exp_start & m_op_wr);
      check("rnd_start_rd", start_rd, exp_start & ~m_op_wr);
      check("rnd_busy", busy, m_inflight);
      if (m_inflight) begin
        check("rnd_addr", addr, m_addr);
        check("rnd_wdata", wdata, m_wd);
      end
      exp_ack = m_inflight && (cyc == m_done_cyc + 1);
      check("rnd_ack0", ack0, exp_ack && (m_port == 1'b0));
      check("rnd_ack1", ack1, exp_ack && (m_port == 1'b1));
      busy_now = m_inflight;
      if (exp_ack) begin
        if (!m_op_wr) m_rdata[m_port] = m_eng;
        check("rnd_rdata0", rdata0, m_rdata[0]);
        check("rnd_rdata1", rdata1, m_rdata[1]);
        check("rnd_err", {err0, err1}, 0);
        $display("rnd txn %0d: port %0d %s addr 0x%02h wdata 0x%02h rdata 0x%02h",
                 n_txn, m_port, m_op_wr ? "WR" : "RD", m_addr, m_wd, m_port ? rdata1 : rdata0);
        n_txn++;
        m_last = m_port;
        m_inflight = 1'b0;
        if (m_op_wr) p_wr[m_port] = 1'b0;
        else p_rd[m_port] = 1'b0;
      end
      m_idle_prev = ~busy_now;

      for (int p = 0; p < 2; p++) begin
        if (!(p_wr[p] | p_rd[p]) && ($urandom_range(0, 2) == 0)) begin
          kind = int'($urandom_range(1, 3));
          p_wr[p] = (kind != 2);
          p_rd[p] = (kind != 1);
        end
        if ($urandom_range(0, 3) == 0) p_addr[p] = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) p_wd[p] = 8'($urandom_range(0, 255));
      end
      set_req(0, p_wr[0], p_rd[0], p_addr[0], p_wd[0]);
      set_req(1, p_wr[1], p_rd[1], p_addr[1], p_wd[1]);

      done_wr = 1'b0; done_rd = 1'b0;
      rdata = 8'($urandom_range(0, 255));
      if (m_inflight) begin
        if (cyc == m_done_cyc) begin
          if (m_op_wr) done_wr = 1'b1; else done_rd = 1'b1;
          rdata = m_eng;
        end else if ((cyc == m_start_cyc) && ($urandom_range(0, 3) == 0)) begin
          if (m_op_wr) done_wr = 1'b1; else done_rd = 1'b1;
        end
        if ($urandom_range(0, 2) == 0) begin
          if (m_op_wr) done_rd = 1'b1; else done_wr = 1'b1;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        done_wr = 1'($urandom_range(0, 1));
        done_rd = 1'($urandom_range(0, 1));
      end
    end
    check("rnd_some_txns", (n_txn > 100), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
